rv16_fu_dispatch: RTL and testbench



---
 rtl/rv16_pkg.sv | 25 ++
 rtl/rv16_fu_slot.sv | 45 ++++
 rtl/rv16_fu_dispatch.sv | 90 +++++++++
 tb/tb_rv16_fu_dispatch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv16_pkg.sv
// Shared types and constants for the rv16 execute-stage operand dispatcher.
// Unit index equals opcode value.
package rv16_pkg;

    localparam int unsigned RV16_DATA   = 16;
    localparam int unsigned RV16_OPW    = 4;
    localparam int unsigned RV16_NUM_FU = 7;

    typedef enum logic [RV16_OPW-1:0] {
        FuAdd = 4'd0,
        FuSub = 4'd1,
        FuMul = 4'd2,
        FuDiv = 4'd3,
        FuXor = 4'd4,
        FuAnd = 4'd5,
        FuOr  = 4'd6
    } fu_op_e;

    typedef struct packed {
        logic [RV16_OPW-1:0]  opcode;
        logic [RV16_DATA-1:0] rs1;
        logic [RV16_DATA-1:0] rs2;
    } fu_bundle_t;

endpackage

// File: rtl/rv16_fu_slot.sv
// One-entry valid/ready holding register for a single functional unit.
// Supports load, drain and same-cycle load+drain for full-rate pass-through.
module rv16_fu_slot
    import rv16_pkg::*;
#(
    parameter int unsigned DATA = RV16_DATA
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [DATA-1:0] load_rs1,
    input  logic [DATA-1:0] load_rs2,
    input  logic            ready,
    output logic            valid,
    output logic [DATA-1:0] rs1,
    output logic [DATA-1:0] rs2
);

    logic            valid_q, valid_d;
    logic [DATA-1:0] rs1_q, rs2_q;

    always_comb begin
        valid_d = load | (valid_q & ~ready);
    end

    // Data is only written on load; it is left in place after a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                rs1_q <= load_rs1;
                rs2_q <= load_rs2;
            end
        end
    end

    assign valid = valid_q;
    assign rs1   = rs1_q;
    assign rs2   = rs2_q;

endmodule

// File: rtl/rv16_fu_dispatch.sv
// Registered operand dispatcher: decodes opcode to a functional unit, parks operands in that
// unit's holding slot under valid/ready back-pressure, and flags/counts illegal opcodes.
module rv16_fu_dispatch
    import rv16_pkg::*;
#(
    parameter int unsigned DATA   = RV16_DATA,
    parameter int unsigned OPW    = RV16_OPW,
    parameter int unsigned NUM_FU = RV16_NUM_FU,
    parameter int unsigned ERRW   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OPW-1:0]         in_opcode,
    input  logic [DATA-1:0]        in_rs1,
    input  logic [DATA-1:0]        in_rs2,
    output logic [NUM_FU-1:0]      fu_valid,
    input  logic [NUM_FU-1:0]      fu_ready,
    output logic [NUM_FU*DATA-1:0] fu_rs1,
    output logic [NUM_FU*DATA-1:0] fu_rs2,
    output logic                   illegal,
    output logic [ERRW-1:0]        illegal_cnt
);

    logic              legal;
    logic              slot_free;
    logic              accept;
    logic [NUM_FU-1:0] load;
    logic              illegal_q, illegal_d;
    logic [ERRW-1:0]   cnt_q, cnt_d;

    // Decode does not look at in_valid, so in_ready is meaningful even when idle.
    always_comb begin
        legal     = 32'(in_opcode) < NUM_FU;
        slot_free = 1'b1;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            if (32'(in_opcode) == k) begin
                slot_free = ~fu_valid[k] | fu_ready[k];
            end
        end
        in_ready = legal ? slot_free : 1'b1;
        accept   = in_valid & in_ready;
    end

    always_comb begin
        load = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            load[k] = accept & legal & (32'(in_opcode) == k);
        end
    end

    for (genvar k = 0; k < NUM_FU; k++) begin : g_slot
        rv16_fu_slot #(
            .DATA (DATA)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[k]),
            .load_rs1 (in_rs1),
            .load_rs2 (in_rs2),
            .ready    (fu_ready[k]),
            .valid    (fu_valid[k]),
            .rs1      (fu_rs1[k*DATA +: DATA]),
            .rs2      (fu_rs2[k*DATA +: DATA])
        );
    end

    always_comb begin
        illegal_d = accept & ~legal;
        cnt_d     = cnt_q;
        if (illegal_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign illegal     = illegal_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_rv16_fu_dispatch.sv
// Randomized + directed bench for rv16_fu_dispatch against a per-unit queue model.
// A second instance with ERRW=2 shares the stimulus to exercise counter saturation.
module tb_rv16_fu_dispatch;
    import rv16_pkg::*;

    localparam int unsigned DATA   = 16;
    localparam int unsigned OPW    = 4;
    localparam int unsigned NUM_FU = 7;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   in_valid;
    logic [OPW-1:0]         in_opcode;
    logic [DATA-1:0]        in_rs1, in_rs2;
    logic [NUM_FU-1:0]      fu_ready;

    logic                   in_ready, in_ready2;
    logic [NUM_FU-1:0]      fu_valid, fu_valid2;
    logic [NUM_FU*DATA-1:0] fu_rs1, fu_rs2, fu_rs1_2, fu_rs2_2;
    logic                   illegal, illegal2;
    logic [7:0]             illegal_cnt;
    logic [1:0]             illegal_cnt2;

    always #5 clk = ~clk;

    rv16_fu_dispatch #(.DATA(DATA), .OPW(OPW), .NUM_FU(NUM_FU), .ERRW(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .fu_valid    (fu_valid),
        .fu_ready    (fu_ready),
        .fu_rs1      (fu_rs1),
        .fu_rs2      (fu_rs2),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    rv16_fu_dispatch #(.DATA(DATA), .OPW(OPW), .NUM_FU(NUM_FU), .ERRW(2)) dut_e2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready2),
        .in_opcode   (in_opcode),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .fu_valid    (fu_valid2),
        .fu_ready    (fu_ready),
        .fu_rs1      (fu_rs1_2),
        .fu_rs2      (fu_rs2_2),
        .illegal     (illegal2),
        .illegal_cnt (illegal_cnt2)
    );

    // Reference model: each unit is a queue of accepted-but-undelivered bundles (at most one).
    fu_bundle_t q[NUM_FU][$];
    bit         exp_illegal;
    int         exp_cnt, exp_cnt2;
    int         n_checks, n_fail;
    int         n_pushed, n_delivered;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < NUM_FU; k++) begin
            check($sformatf("fu_valid[%0d]", k), 64'(fu_valid[k]), 64'(q[k].size() != 0));
            check($sformatf("fu_valid2[%0d]", k), 64'(fu_valid2[k]), 64'(q[k].size() != 0));
            if (q[k].size() != 0) begin
                check($sformatf("fu_rs1[%0d]", k), 64'(fu_rs1[k*DATA +: DATA]), 64'(q[k][0].rs1));
                check($sformatf("fu_rs2[%0d]", k), 64'(fu_rs2[k*DATA +: DATA]), 64'(q[k][0].rs2));
                check($sformatf("fu_rs1_2[%0d]", k), 64'(fu_rs1_2[k*DATA +: DATA]),
                      64'(q[k][0].rs1));
            end
        end
        check("illegal", 64'(illegal), 64'(exp_illegal));
        check("illegal2", 64'(illegal2), 64'(exp_illegal));
        check("illegal_cnt", 64'(illegal_cnt), 64'(exp_cnt));
        check("illegal_cnt2", 64'(illegal_cnt2), 64'(exp_cnt2));
    endtask

    // Called at posedge+1; returns at the next posedge+1 with the model advanced.
    task automatic step(input bit v, input logic [OPW-1:0] op, input logic [DATA-1:0] a,
                        input logic [DATA-1:0] b, input logic [NUM_FU-1:0] rdy, output bit acc);
        bit legal, exp_rdy;
        fu_bundle_t bnd;
        in_valid  = v;
        in_opcode = op;
        in_rs1    = a;
        in_rs2    = b;
        fu_ready  = rdy;
        #1;
        check_outputs();
        legal   = (op < NUM_FU);
        exp_rdy = !legal || (q[op].size() == 0) || rdy[op];
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("in_ready2", 64'(in_ready2), 64'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        for (int k = 0; k < NUM_FU; k++) begin
            if (q[k].size() != 0 && rdy[k]) begin
                void'(q[k].pop_front());
                n_delivered++;
            end
        end
        exp_illegal = acc && !legal;
        if (acc && !legal) begin
            if (exp_cnt < 255) exp_cnt++;
            if (exp_cnt2 < 3) exp_cnt2++;
        end
        if (acc && legal) begin
            bnd.opcode = op;
            bnd.rs1    = a;
            bnd.rs2    = b;
            q[op].push_back(bnd);
            n_pushed++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_fu_valid", 64'(fu_valid), 64'd0);
        check("rst_rs1_zero", 64'(fu_rs1 == '0), 64'd1);
        check("rst_rs2_zero", 64'(fu_rs2 == '0), 64'd1);
        check("rst_illegal", 64'(illegal), 64'd0);
        check("rst_cnt", 64'(illegal_cnt), 64'd0);
        check("rst_cnt2", 64'(illegal_cnt2), 64'd0);
        for (int k = 0; k < NUM_FU; k++) q[k].delete();
        exp_illegal = 1'b0;
        exp_cnt     = 0;
        exp_cnt2    = 0;
        n_pushed    = 0;
        n_delivered = 0;
        in_valid    = 1'b0;
        fu_ready    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc, pend;
        logic [OPW-1:0]  op;
        logic [DATA-1:0] a, b, d1, d2;
        bit v;
        n_checks = 0;
        n_fail   = 0;
        in_valid = 1'b0;
        in_opcode = '0;
        in_rs1 = '0;
        in_rs2 = '0;
        fu_ready = '0;
        #2;
        do_reset();

        // Illegal opcodes: consumed, no slot touched, counter increments / saturates at 3.
        step(1'b1, 4'd7, 16'hAAAA, 16'h5555, '0, acc);
        check("illegal7_acc", 64'(acc), 64'd1);
        check("illegal7_pulse", 64'(illegal), 64'd1);
        step(1'b1, 4'd15, 16'hBBBB, 16'h6666, '0, acc);
        check("illegal15_cnt", 64'(illegal_cnt), 64'd2);
        check("illegal15_fu_valid", 64'(fu_valid), 64'd0);
        step(1'b0, 4'd0, '0, '0, '0, acc);
        check("illegal_idle", 64'(illegal), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'd9, 16'h1, 16'h2, '0, acc);
        check("cnt_after5", 64'(illegal_cnt), 64'd5);
        check("cnt2_sat", 64'(illegal_cnt2), 64'd3);
        check("sat_still_pulses", 64'(illegal2), 64'd1);

        // Single dispatch and back-pressure on a full slot.
        step(1'b1, 4'd2, 16'h1234, 16'h00FF, '0, acc);
        check("single_fu_valid", 64'(fu_valid), 64'b0000100);
        check("single_rs1", 64'(fu_rs1[2*DATA +: DATA]), 64'h1234);
        check("single_rs2", 64'(fu_rs2[2*DATA +: DATA]), 64'h00FF);
        step(1'b1, 4'd2, 16'hCAFE, 16'hBEEF, '0, acc);
        check("single_blocked", 64'(acc), 64'd0);
        step(1'b1, 4'd2, 16'hCAFE, 16'hBEEF, 7'b0000100, acc);
        check("single_release", 64'(acc), 64'd1);
        check("single_new_rs1", 64'(fu_rs1[2*DATA +: DATA]), 64'hCAFE);
        step(1'b0, 4'd0, '0, '0, '1, acc);

        // Back-to-back to unit 0 with constant ready: full rate, new data every cycle.
        for (int i = 0; i < 8; i++) begin
            d1 = 16'($urandom);
            d2 = 16'($urandom);
            step(1'b1, 4'd0, d1, d2, 7'b0000001, acc);
            check("b2b_acc", 64'(acc), 64'd1);
            check("b2b_valid", 64'(fu_valid[0]), 64'd1);
            check("b2b_rs1", 64'(fu_rs1[0 +: DATA]), 64'(d1));
        end
        step(1'b0, 4'd0, '0, '0, '1, acc);

        // Parallel units, then release only unit 4.
        step(1'b1, 4'd0, 16'h0100, 16'h0001, '0, acc);
        step(1'b1, 4'd1, 16'h0101, 16'h0002, '0, acc);
        step(1'b1, 4'd4, 16'h0104, 16'h0003, '0, acc);
        step(1'b1, 4'd6, 16'h0106, 16'h0004, '0, acc);
        check("parallel_valid", 64'(fu_valid), 64'b1010011);
        step(1'b0, 4'd0, '0, '0, 7'b0010000, acc);
        check("release4_valid", 64'(fu_valid), 64'b1000011);
        step(1'b0, 4'd0, '0, '0, '1, acc);

        // Random traffic; an unaccepted bundle is held stable until it goes.
        pend = 1'b0;
        v = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        for (int c = 0; c < 1200; c++) begin
            if (c == 600) begin
                do_reset();
                pend = 1'b0;
            end
            if (!pend) begin
                v  = ($urandom_range(0, 3) != 0);
                op = 4'($urandom_range(0, 9));
                if ($urandom_range(0, 15) == 0) op = 4'hF;
                a  = 16'($urandom);
                b  = 16'($urandom);
            end
            step(v, op, a, b, 7'($urandom), acc);
            pend = v && !acc;
        end

        // Drain everything and confirm each accepted bundle came out exactly once.
        step(1'b0, 4'd0, '0, '0, '1, acc);
        step(1'b0, 4'd0, '0, '0, '1, acc);
        check("all_delivered", 64'(n_delivered), 64'(n_pushed));
        check("final_fu_valid", 64'(fu_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
